alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Every operation except MUL completes on the accepting edge. MUL runs a
// shift-add over WIDTH cycles before its result is loaded. Carry from the
// last loaded result is kept in c_q and feeds ADC/SBC.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             op_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    CNT_END = CW'(WIDTH);

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_NOT = 4'd3,
    OP_OR   = 4'd4,  OP_AND = 4'd5,  OP_XOR = 4'd6,  OP_SHL = 4'd7,
    OP_SHR  = 4'd8,  OP_ADC = 4'd9,  OP_SBC = 4'd10, OP_CMP = 4'd11,
    OP_MUL  = 4'd12
  } op_e;

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 is_mul;
  logic                 mul_done;
  logic [CW-1:0]        cnt_inc;
  logic [2*WIDTH-1:0]   mul_acc_next;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v, alu_err;
  logic                 cin;
  logic [WIDTH:0]       sum, diff, shl_ext, shr_ext;
  logic                 big_shift;

  assign accept       = in_valid && in_ready;
  assign is_mul       = (opcode == OP_MUL);
  assign cnt_inc      = cnt_q + 1'b1;
  assign mul_done     = (state_q == MUL_BUSY) && (cnt_inc == CNT_END);
  assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: MUL enters the busy state, leaves when the count hits WIDTH.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done)         state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and the output slot is free or draining.
  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  end

  // Single-cycle ALU result and flags for the operation being accepted.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_err   = 1'b0;
    cin       = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? c_q : 1'b0;
    sum       = {1'b0, in_1} + {1'b0, in_2} + {{WIDTH{1'b0}}, cin};
    diff      = {1'b0, in_1} - {1'b0, in_2} - {{WIDTH{1'b0}}, cin};
    shl_ext   = {1'b0, in_1} << in_2;
    shr_ext   = {in_1, 1'b0} >> in_2;
    big_shift = (in_2 >= WIDTH_V);
    case (opcode)
      OP_PASS: alu_res = in_1;
      OP_NOT:  alu_res = ~in_1;
      OP_OR:   alu_res = in_1 | in_2;
      OP_AND:  alu_res = in_1 & in_2;
      OP_XOR:  alu_res = in_1 ^ in_2;
      OP_ADD, OP_ADC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in_1[WIDTH-1] == in_2[WIDTH-1]) &&
                  (sum[WIDTH-1] != in_1[WIDTH-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        // A negative (WIDTH+1)-bit difference means a borrow occurred.
        alu_res = (opcode == OP_CMP) ? in_1 : diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (in_1[WIDTH-1] != in_2[WIDTH-1]) &&
                  (diff[WIDTH-1] != in_1[WIDTH-1]);
      end
      OP_SHL: begin
        // Bit WIDTH of the extended shift is the last bit shifted out.
        alu_res = big_shift ? '0 : shl_ext[WIDTH-1:0];
        alu_c   = big_shift ? 1'b0 : shl_ext[WIDTH];
      end
      OP_SHR: begin
        // Bit 0 of the extended shift is the last bit shifted out.
        alu_res = big_shift ? '0 : shr_ext[WIDTH:1];
        alu_c   = big_shift ? 1'b0 : shr_ext[0];
      end
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Next values for the multiplier datapath and the output/flag registers.
  always_comb begin
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    out_d       = out_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    if (out_ready) out_valid_d = 1'b0;

    if (accept && is_mul) begin
      // Operands are captured here; later input changes cannot disturb the multiply.
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, in_1};
      mplier_d = in_2;
      acc_d    = '0;
    end else if (accept) begin
      out_d       = alu_res;
      z_d         = !alu_err && (alu_res == '0);
      n_d         = alu_res[WIDTH-1];
      c_d         = alu_c;
      v_d         = alu_v;
      err_d       = alu_err;
      out_valid_d = 1'b1;
    end

    if (state_q == MUL_BUSY) begin
      cnt_d    = mul_done ? '0 : cnt_inc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = mul_acc_next;
      if (mul_done) begin
        out_d       = mul_acc_next[WIDTH-1:0];
        z_d         = (mul_acc_next[WIDTH-1:0] == '0);
        n_d         = mul_acc_next[WIDTH-1];
        c_d         = |mul_acc_next[2*WIDTH-1:WIDTH];
        v_d         = 1'b0;
        err_d       = 1'b0;
        out_valid_d = 1'b1;
      end
    end
  end

  // Datapath and result registers; reset clears everything and aborts a multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign op_err    = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 with hand-computed expectations.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'd0;
  logic [W-1:0] in_1 = '0;
  logic [W-1:0] in_2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         flag_z, flag_n, flag_c, flag_v, op_err;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in_1(in_1), .in_2(in_2),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one op right after a falling edge; returns at the next falling edge.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    opcode   = op;
    in_1     = a;
    in_2     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Compare the whole result bundle: {err, v, c, n, z, out}.
  task automatic check_res(input string tag, input logic [W-1:0] o, input logic z,
                           input logic n, input logic c, input logic v, input logic e);
    check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " result"}, {19'd0, op_err, flag_v, flag_c, flag_n, flag_z, out},
          {19'd0, e, v, c, n, z, o});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset outs", {19'd0, op_err, flag_v, flag_c, flag_n, flag_z, out}, 32'd0);
    check("reset valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after reset", {31'd0, in_ready}, 32'd1);

    // Arithmetic and carry chaining through c_reg.
    run_op(4'd1, 8'hFF, 8'h01);  check_res("add ff+01", 8'h00, 1, 0, 1, 0, 0);
    run_op(4'd9, 8'h01, 8'h01);  check_res("adc c=1",   8'h03, 0, 0, 0, 0, 0);
    run_op(4'd2, 8'h80, 8'h01);  check_res("sub 80-01", 8'h7F, 0, 0, 0, 1, 0);
    run_op(4'd9, 8'h10, 8'h00);  check_res("adc c=0",   8'h10, 0, 0, 0, 0, 0);
    run_op(4'd2, 8'h00, 8'h01);  check_res("sub borrow", 8'hFF, 0, 1, 1, 0, 0);
    run_op(4'd10, 8'h05, 8'h01); check_res("sbc b=1",   8'h03, 0, 0, 0, 0, 0);
    run_op(4'd11, 8'h03, 8'h05); check_res("cmp 03,05", 8'h03, 0, 0, 1, 0, 0);

    // Multiply: busy for 8 cycles, stray requests ignored, result in cycle 9.
    run_op(4'd12, 8'h12, 8'h10);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mul busy %0d", i), {31'd0, in_ready}, 32'd0);
      if (i == 3) check("mul no early valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      opcode   = 4'd1;
      in_1     = 8'(i + 1);
      in_2     = 8'h77;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_res("mul 12*10", 8'h20, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("stray ignored", {31'd0, out_valid}, 32'd0);

    // Reset during a multiply: outputs clear at once, no stale result later.
    run_op(4'd12, 8'h33, 8'h05);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid-mul outs", {19'd0, op_err, flag_v, flag_c, flag_n, flag_z, out}, 32'd0);
    check("rst mid-mul valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after abort", {31'd0, in_ready}, 32'd1);
    repeat (10) @(negedge clk);
    check("no stale mul", {31'd0, out_valid}, 32'd0);
    check("no stale out", {24'd0, out}, 32'd0);
    run_op(4'd9, 8'h10, 8'h00);  check_res("adc c_reg cleared", 8'h10, 0, 0, 0, 0, 0);

    // Back-pressure: result held while out_ready is low.
    run_op(4'd5, 8'hF0, 8'h3C);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      opcode   = 4'd4;
      in_1     = 8'hAA;
      @(negedge clk);
      check_res($sformatf("stall %0d", i), 8'h30, 0, 0, 0, 0, 0);
      check($sformatf("stall ready %0d", i), {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("drained valid", {31'd0, out_valid}, 32'd0);
    check("drained ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops, one result per cycle.
    opcode = 4'd4; in_1 = 8'h0F; in_2 = 8'h30; in_valid = 1'b1;
    @(negedge clk); check_res("b2b or",  8'h3F, 0, 0, 0, 0, 0);
    opcode = 4'd6; in_1 = 8'hFF; in_2 = 8'h0F;
    @(negedge clk); check_res("b2b xor", 8'hF0, 0, 1, 0, 0, 0);
    opcode = 4'd3; in_1 = 8'h55;
    @(negedge clk); check_res("b2b not", 8'hAA, 0, 1, 0, 0, 0);
    opcode = 4'd0; in_1 = 8'h00;
    @(negedge clk); check_res("b2b pass0", 8'h00, 1, 0, 0, 0, 0);
    in_valid = 1'b0;

    // Shifts, including zero and oversize amounts.
    run_op(4'd7, 8'h81, 8'd1);  check_res("shl 81<<1", 8'h02, 0, 0, 1, 0, 0);
    run_op(4'd8, 8'h81, 8'd9);  check_res("shr 81>>9", 8'h00, 1, 0, 0, 0, 0);
    run_op(4'd8, 8'h81, 8'd1);  check_res("shr 81>>1", 8'h40, 0, 0, 1, 0, 0);
    run_op(4'd7, 8'h01, 8'd0);  check_res("shl by 0",  8'h01, 0, 0, 0, 0, 0);
    run_op(4'd7, 8'hFF, 8'd8);  check_res("shl by 8",  8'h00, 1, 0, 0, 0, 0);

    // Reserved opcode, then a legal op clears op_err.
    run_op(4'd14, 8'h12, 8'h34); check_res("reserved 14", 8'h00, 0, 0, 0, 0, 1);
    run_op(4'd0, 8'h5A, 8'h00);  check_res("pass 5a", 8'h5A, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
